g_reg_file_sb: RTL
==================

Name: g_reg_file_sb

Overview:
Parametrised general-register file with an integrated scoreboard. It succeeds the single-bit-reservation register cell. Each register carries a reservation counter, so multiple in-flight writes to the same register (WAW) are tracked. The block provides N_WB writeback ports, N_RD read ports with same-cycle writeback bypass, and an optional hard-wired zero register. It sits between decode/issue (reads, reservations) and the writeback stage.

Parameters:
W_OPR, 32, operand/register data width
N_REG, 32, number of registers
A_W, 5, register address width (2**A_W >= N_REG)
N_RD, 2, number of read ports
N_WB, 2, number of writeback ports
CNT_W, 2, reservation counter width; max outstanding writes per register = 2**CNT_W-1
ZERO_R0, 1, 1 = register 0 reads as zero, never reserved, writes ignored

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
rd_addr_i  in  N_RD*A_W  read addresses, port k at [k*A_W +: A_W]
rd_data_o  out  N_RD*W_OPR  read data, bypassed
rd_ready_o  out  N_RD  read data final (no outstanding writes remain after this cycle's writebacks)
res_en_i  in  1  reserve request
res_addr_i  in  A_W  register to reserve
res_full_o  out  1  counter of res_addr_i saturated; reserve will be dropped
wb_en_i  in  N_WB  writeback enables
wb_addr_i  in  N_WB*A_W  writeback addresses
wb_data_i  in  N_WB*W_OPR  writeback data
busy_o  out  N_REG  per-register counter != 0

Behaviour:
- Reset (async, reset=0): all data cells = 0 and all counters = 0. Consequently busy_o = 0, res_full_o = 0, rd_ready_o = all 1s, and rd_data_o = 0 for every read port.
- Writeback:
  - On posedge, for every k with wb_en_i[k]=1 and valid addr, data_cell[wb_addr] <= wb_data[k].
  - Multiple ports to the same addr in one cycle: highest k wins the data.
- Counter update per register r, each posedge:
  - next = cnt + inc - dec.
  - inc = 1 if res_en_i, res_addr_i==r, and cnt != max; else 0.
  - dec = number of WB ports hitting r.
  - Result saturates at 0 (an underflow does not wrap) and at max.
  - Reserve and writeback to the same register in the same cycle are both applied, e.g. cnt 1 -> 1.
- res_full_o: combinational, (cnt[res_addr_i] == 2**CNT_W-1). A reserve issued while full is dropped with no counter change; the issuer must stall.
- Read, combinational (zero-cycle latency):
  - rd_data = wb_data of the highest-index WB port hitting rd_addr this cycle; otherwise data_cell[rd_addr].
  - rd_ready = (cnt[rd_addr] - hits(rd_addr) <= 0).
  - A reserve in the same cycle does not affect the current-cycle rd_ready.
- ZERO_R0=1 and addr 0:
  - rd_data = 0 and rd_ready = 1.
  - Reserve is ignored and res_full_o = 0.
  - WB is ignored; the counter stays 0 and busy_o[0] stays 0.
- Addresses >= N_REG:
  - Reads return 0 with ready = 1.
  - Reserve and WB are ignored.
- busy_o reflects the registered counters only, with no bypass.
- Reset asserted mid-operation clears all counters and data immediately. Writebacks arriving after reset deassertion write data; their decrement saturates at 0.

Test Plan:
- Reset, then read r5 on port 0 -> rd_data=0, rd_ready=1, busy_o=0. Assert reset mid-run with busy_o[3]=1 -> busy_o=0 immediately.
- Reserve r3, then next cycle read r3 -> rd_ready=0, busy_o[3]=1. WB r3=0xDEADBEEF in a later cycle with a same-cycle read -> rd_data=0xDEADBEEF, rd_ready=1. Following cycle -> busy_o[3]=0 and the cell holds 0xDEADBEEF.
- Reserve r7 three times (CNT_W=2) -> res_full_o=1. A fourth reserve is dropped. Three WBs are needed before busy_o[7]=0, and rd_ready=1 only in the cycle of the third WB.
- WB port0 and port1 both to r9 with 0x11 and 0x22, cnt=2 -> rd bypass = 0x22, stored 0x22, cnt -> 0.
- Reserve r4 and WB r4 in the same cycle with cnt=1 -> cnt stays 1, busy_o[4]=1.
- ZERO_R0=1: reserve r0 and WB r0=0x5 -> busy_o[0]=0, read r0 = 0, rd_ready=1.

Source files
------------

// File: rtl/g_reg_file_sb_if.sv
// g_reg_file_sb_if
// Bus bundle between the issue/writeback side (master) and the register file
// with scoreboard (slave).
//   rd_addr_i  : N_RD packed read addresses, port k at [k*A_W +: A_W]
//   rd_data_o  : N_RD packed read data, writeback-bypassed
//   rd_ready_o : per read port, data is final after this cycle's writebacks
//   res_en_i   : reserve request
//   res_addr_i : register to reserve
//   res_full_o : reservation counter of res_addr_i is saturated
//   wb_en_i    : per writeback port enable
//   wb_addr_i  : N_WB packed writeback addresses
//   wb_data_i  : N_WB packed writeback data
//   busy_o     : per register, reservation counter is non-zero
interface g_reg_file_sb_if #(
  parameter int W_OPR = 32,
  parameter int N_REG = 32,
  parameter int A_W   = 5,
  parameter int N_RD  = 2,
  parameter int N_WB  = 2
);

  logic [N_RD*A_W-1:0]   rd_addr_i;
  logic [N_RD*W_OPR-1:0] rd_data_o;
  logic [N_RD-1:0]       rd_ready_o;
  logic                  res_en_i;
  logic [A_W-1:0]        res_addr_i;
  logic                  res_full_o;
  logic [N_WB-1:0]       wb_en_i;
  logic [N_WB*A_W-1:0]   wb_addr_i;
  logic [N_WB*W_OPR-1:0] wb_data_i;
  logic [N_REG-1:0]      busy_o;

  modport master (
    output rd_addr_i, res_en_i, res_addr_i, wb_en_i, wb_addr_i, wb_data_i,
    input  rd_data_o, rd_ready_o, res_full_o, busy_o
  );

  modport slave (
    input  rd_addr_i, res_en_i, res_addr_i, wb_en_i, wb_addr_i, wb_data_i,
    output rd_data_o, rd_ready_o, res_full_o, busy_o
  );

endinterface

// File: rtl/g_reg_file_sb.sv
// g_reg_file_sb
// General register file with a per-register reservation counter, so several
// in-flight writes to one register are tracked. Reads are combinational and
// bypass same-cycle writebacks. Register 0 can be hard-wired to zero.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-low reset (clears data and counters)
//   bus   : g_reg_file_sb_if slave modport (read, reserve, writeback, busy)
module g_reg_file_sb #(
  parameter int W_OPR   = 32,
  parameter int N_REG   = 32,
  parameter int A_W     = 5,
  parameter int N_RD    = 2,
  parameter int N_WB    = 2,
  parameter int CNT_W   = 2,
  parameter int ZERO_R0 = 1
) (
  input  logic             clk,
  input  logic             reset,
  g_reg_file_sb_if.slave   bus
);

  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic [W_OPR-1:0] data_q [N_REG];
  logic [CNT_W-1:0] cnt_q  [N_REG];
  logic [CNT_W-1:0] cnt_d  [N_REG];

  logic [N_RD*W_OPR-1:0] rd_data_v;
  logic [N_RD-1:0]       rd_ready_v;
  logic [N_REG-1:0]      busy_v;

  // An address takes part in reserve/writeback/tracking only if it maps to a
  // real register that is not the hard-wired zero register.
  function automatic logic addr_ok(input logic [A_W-1:0] a);
    return (int'(a) < N_REG) && !((ZERO_R0 != 0) && (a == '0));
  endfunction

  // Next counter value: +1 for an accepted reserve, -1 per writeback hit,
  // clamped to [0, CNT_MAX] so stray writebacks never wrap the counter.
  always_comb begin
    int t;
    t = 0;
    for (int r = 0; r < N_REG; r++) begin
      t = int'(cnt_q[r]);
      if (bus.res_en_i && addr_ok(bus.res_addr_i) && (int'(bus.res_addr_i) == r)
          && (int'(cnt_q[r]) != CNT_MAX))
        t = t + 1;
      for (int k = 0; k < N_WB; k++) begin
        if (bus.wb_en_i[k] && addr_ok(bus.wb_addr_i[k*A_W +: A_W])
            && (int'(bus.wb_addr_i[k*A_W +: A_W]) == r))
          t = t - 1;
      end
      if (t < 0) t = 0;
      if (t > CNT_MAX) t = CNT_MAX;
      cnt_d[r] = CNT_W'(t);
    end
  end

  // State registers. Writeback ports are applied in ascending order so the
  // highest-index port wins when several target the same register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < N_REG; r++) begin
        data_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
    end else begin
      for (int r = 0; r < N_REG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      for (int k = 0; k < N_WB; k++) begin
        if (bus.wb_en_i[k] && addr_ok(bus.wb_addr_i[k*A_W +: A_W]))
          data_q[bus.wb_addr_i[k*A_W +: A_W]] <= bus.wb_data_i[k*W_OPR +: W_OPR];
      end
    end
  end

  // Read ports: bypass from the highest-index hitting writeback, and call the
  // data final once this cycle's writebacks retire every outstanding write.
  // Invalid and zero-register addresses keep the defaults (0, ready).
  always_comb begin
    logic [A_W-1:0] a;
    int hits;
    rd_data_v  = '0;
    rd_ready_v = '1;
    a          = '0;
    hits       = 0;
    for (int p = 0; p < N_RD; p++) begin
      a    = bus.rd_addr_i[p*A_W +: A_W];
      hits = 0;
      if (addr_ok(a)) begin
        rd_data_v[p*W_OPR +: W_OPR] = data_q[a];
        for (int k = 0; k < N_WB; k++) begin
          if (bus.wb_en_i[k] && (bus.wb_addr_i[k*A_W +: A_W] == a)) begin
            rd_data_v[p*W_OPR +: W_OPR] = bus.wb_data_i[k*W_OPR +: W_OPR];
            hits = hits + 1;
          end
        end
        rd_ready_v[p] = (int'(cnt_q[a]) - hits) <= 0;
      end
    end
  end

  always_comb begin
    busy_v = '0;
    for (int r = 0; r < N_REG; r++) begin
      busy_v[r] = (cnt_q[r] != '0);
    end
  end

  assign bus.rd_data_o  = rd_data_v;
  assign bus.rd_ready_o = rd_ready_v;
  assign bus.busy_o     = busy_v;
  assign bus.res_full_o = addr_ok(bus.res_addr_i)
                          && (int'(cnt_q[bus.res_addr_i]) == CNT_MAX);

endmodule
